keypad_event_port: RTL and testbench

- Parametrised successor to the push-button input register on the PicoBlaze input bus.
- Synchronises and debounces N_KEYS raw buttons and latches each press as a sticky pending event.
- Presents per-key event codes, a pending bitmap and a mask register at fixed port IDs.
- Generates one interrupt with an acknowledge handshake, so firmware does not need to poll.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/key_debouncer.sv | 50 +++++
 rtl/keypad_event_port.sv | 116 +++++++++++
 tb/tb_keypad_event_port.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants for the keypad event port: default port map, event code base
// and interrupt FSM encodings (also consumed by the firmware constant generator).
package keypad_pkg;

    localparam int unsigned PORT_W = 8;

    localparam logic [PORT_W-1:0] BASE_ID_DEFAULT   = 8'h03;
    localparam logic [PORT_W-1:0] CODE_BASE_DEFAULT = 8'h04;
    localparam logic [PORT_W-1:0] STATUS_ID_DEFAULT = 8'h0E;
    localparam logic [PORT_W-1:0] MASK_ID_DEFAULT   = 8'h0F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Byte address/code of key idx relative to a base, wrapping at 8 bits.
    function automatic logic [PORT_W-1:0] key_offset(input logic [PORT_W-1:0] base,
                                                     input int unsigned idx);
        return PORT_W'(32'(base) + idx);
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Per-key 2-flop synchroniser plus debounce counter; flags each accepted press.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic press_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_q;
    logic [CNT_W-1:0] cnt;

    // Two-stage synchroniser for the asynchronous button level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_q    <= sync_meta;
        end
    end

    // Accept a new level only after it has persisted DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            stable      <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            if (sync_q == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt         <= '0;
                stable      <= sync_q;
                press_pulse <= sync_q;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_event_port.sv
// PicoBlaze keypad port: debounced sticky press events, mask register and
// a single acknowledged interrupt.
module keypad_event_port
    import keypad_pkg::*;
#(
    parameter int unsigned       N_KEYS          = 5,
    parameter int unsigned       DEBOUNCE_CYCLES = 250000,
    parameter logic [PORT_W-1:0] BASE_ID         = BASE_ID_DEFAULT,
    parameter logic [PORT_W-1:0] CODE_BASE       = CODE_BASE_DEFAULT,
    parameter logic [PORT_W-1:0] STATUS_ID       = STATUS_ID_DEFAULT,
    parameter logic [PORT_W-1:0] MASK_ID         = MASK_ID_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_in,
    input  logic [PORT_W-1:0] port_id,
    input  logic              read_strobe,
    input  logic              write_strobe,
    input  logic [PORT_W-1:0] out_port,
    input  logic              interrupt_ack,
    output logic [PORT_W-1:0] in_port,
    output logic              interrupt
);

    logic [N_KEYS-1:0] key_stable;
    logic [N_KEYS-1:0] press_vec;
    logic [N_KEYS-1:0] pending;
    logic [N_KEYS-1:0] mask;
    logic [N_KEYS-1:0] rd_clear;
    logic              irq_req;
    irq_state_t        state_q;
    irq_state_t        state_d;
    logic              interrupt_d;
    logic              unused_bits;

    // Stable levels are only observed through press pulses; upper data bits may be unused.
    assign unused_bits = ^{key_stable, out_port};

    // One debouncer per key.
    for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk        (clk),
            .reset      (reset),
            .raw        (key_in[g]),
            .stable     (key_stable[g]),
            .press_pulse(press_vec[g])
        );
    end

    // Decode clear-on-read of individual key ports.
    always_comb begin
        rd_clear = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            rd_clear[i] = read_strobe && (port_id == key_offset(BASE_ID, i));
        end
    end

    // Sticky pending events (a new press beats a same-cycle clear) and mask register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            mask    <= '1;
        end else begin
            pending <= (pending & ~rd_clear) | press_vec;
            if (write_strobe && (port_id == MASK_ID)) begin
                mask <= out_port[N_KEYS-1:0];
            end
        end
    end

    // Read mux; forced to zero while reset is asserted.
    always_comb begin
        in_port = 8'hFF;
        if (port_id == STATUS_ID) begin
            in_port = PORT_W'(pending);
        end else if (port_id == MASK_ID) begin
            in_port = PORT_W'(mask);
        end
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (port_id == key_offset(BASE_ID, i)) begin
                in_port = pending[i] ? key_offset(CODE_BASE, i) : 8'h00;
            end
        end
        if (reset) begin
            in_port = 8'h00;
        end
    end

    assign irq_req = |(pending & mask);

    // Interrupt FSM state and registered request output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            interrupt <= 1'b0;
        end else begin
            state_q   <= state_d;
            interrupt <= interrupt_d;
        end
    end

    // Next-state: request held until acknowledged, then wait for all enabled events to drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (irq_req)       state_d = REQ;
            REQ:     if (interrupt_ack) state_d = SERVICE;
            SERVICE: if (!irq_req)      state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
        interrupt_d = (state_d == REQ);
    end

endmodule

// File: tb/tb_keypad_event_port.sv
// Self-checking bench for keypad_event_port with a window-based behavioural model.
module tb_keypad_event_port;

    localparam int unsigned NK = 5;
    localparam int unsigned DB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_in;
    logic [7:0]    port_id;
    logic          read_strobe;
    logic          write_strobe;
    logic [7:0]    out_port;
    logic          interrupt_ack;
    logic [7:0]    in_port;
    logic          interrupt;

    int n_tests = 0;
    int n_fail  = 0;

    keypad_event_port #(
        .N_KEYS(NK),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_in       (key_in),
        .port_id      (port_id),
        .read_strobe  (read_strobe),
        .write_strobe (write_strobe),
        .out_port     (out_port),
        .interrupt_ack(interrupt_ack),
        .in_port      (in_port),
        .interrupt    (interrupt)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [DB+1:0] m_hist [NK];
    logic [NK-1:0] m_stable, m_pulse, m_pend, m_mask, m_clr;
    int            m_st;
    logic          m_irq, m_req;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_in(input logic [7:0] id);
        logic [7:0] r;
        r = 8'hFF;
        if (id == 8'h0E) r = 8'(m_pend);
        if (id == 8'h0F) r = 8'(m_mask);
        for (int i = 0; i < int'(NK); i++)
            if (id == 8'(3 + i)) r = m_pend[i] ? 8'(4 + i) : 8'h00;
        return r;
    endfunction

    // Model: a key's accepted level flips once the synchronised input (raw delayed by
    // two samples) has disagreed with it for DB consecutive samples.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int k = 0; k < int'(NK); k++) m_hist[k] = '0;
                m_stable = '0; m_pulse = '0; m_pend = '0; m_mask = '1;
                m_st = 0; m_irq = 1'b0;
            end else begin
                m_req = |(m_pend & m_mask);
                m_clr = '0;
                for (int k = 0; k < int'(NK); k++)
                    if (read_strobe && port_id == 8'(3 + k)) m_clr[k] = 1'b1;
                m_pend = (m_pend & ~m_clr) | m_pulse;
                if (write_strobe && port_id == 8'h0F) m_mask = out_port[NK-1:0];
                case (m_st)
                    0: if (m_req) m_st = 1;
                    1: if (interrupt_ack) m_st = 2;
                    default: if (!m_req) m_st = 0;
                endcase
                m_irq = (m_st == 1);
                m_pulse = '0;
                for (int k = 0; k < int'(NK); k++) begin
                    m_hist[k] = {m_hist[k][DB:0], key_in[k]};
                    if (m_stable[k] == 1'b0 && (&m_hist[k][DB+1:2])) begin
                        m_stable[k] = 1'b1;
                        m_pulse[k]  = 1'b1;
                    end else if (m_stable[k] == 1'b1 && !(|m_hist[k][DB+1:2])) begin
                        m_stable[k] = 1'b0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("model_irq", 32'(interrupt), 32'(m_irq));
                chk("model_in_port", 32'(in_port), 32'(exp_in(port_id)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic peek(input logic [7:0] id, input logic [7:0] exp, input string nm);
        port_id = id;
        #1;
        chk(nm, 32'(in_port), 32'(exp));
    endtask

    task automatic rd(input logic [7:0] id);
        port_id = id; read_strobe = 1'b1; tick(); read_strobe = 1'b0;
    endtask

    task automatic wr_mask(input logic [7:0] d);
        port_id = 8'h0F; out_port = d; write_strobe = 1'b1; tick(); write_strobe = 1'b0;
    endtask

    task automatic ack();
        interrupt_ack = 1'b1; tick(); interrupt_ack = 1'b0;
    endtask

    task automatic wait_pend(input int k, input int maxc, output int n);
        n = 0;
        port_id = 8'h0E; #1;
        while (in_port[k] !== 1'b1 && n < maxc) begin
            tick(); port_id = 8'h0E; #1; n++;
        end
        chk("wait_pend", 32'(in_port[k]), 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1; key_in = '0; port_id = 8'h00; read_strobe = 1'b0;
        write_strobe = 1'b0; out_port = 8'h00; interrupt_ack = 1'b0;
        ticks(2);
        reset = 1'b0;
        tick();
        chk("rst_irq", 32'(interrupt), 32'd0);
        peek(8'h0E, 8'h00, "rst_status");
        peek(8'h0F, 8'h1F, "rst_mask");
        peek(8'h20, 8'hFF, "rst_unmapped");

        // Steady press of key 2.
        key_in[2] = 1'b1;
        wait_pend(2, 12, n);
        chk("press_latency", 32'(n), 32'd7);
        chk("irq_before_req", 32'(interrupt), 32'd0);
        tick();
        chk("irq_rise", 32'(interrupt), 32'd1);
        peek(8'h05, 8'h06, "key2_code");
        rd(8'h05);
        peek(8'h05, 8'h00, "key2_cleared");
        chk("irq_held_until_ack", 32'(interrupt), 32'd1);
        ack();
        chk("irq_fall_after_ack", 32'(interrupt), 32'd0);
        key_in[2] = 1'b0;
        ticks(10);

        // Glitch shorter than the debounce window, then a long pulse.
        key_in[0] = 1'b1; ticks(3); key_in[0] = 1'b0;
        ticks(10);
        peek(8'h0E, 8'h00, "glitch_ignored");
        chk("glitch_no_irq", 32'(interrupt), 32'd0);
        key_in[0] = 1'b1; ticks(10); key_in[0] = 1'b0;
        peek(8'h0E, 8'h01, "long_pulse_pending");
        chk("long_pulse_irq", 32'(interrupt), 32'd1);
        rd(8'h03); ack(); ticks(10);

        // Handshake: presses during SERVICE do not re-raise the interrupt.
        key_in[1] = 1'b1;
        wait_pend(1, 12, n);
        tick();
        chk("hs_irq", 32'(interrupt), 32'd1);
        ack();
        chk("hs_ack_drop", 32'(interrupt), 32'd0);
        key_in[4] = 1'b1;
        wait_pend(4, 12, n);
        chk("svc_no_reassert", 32'(interrupt), 32'd0);
        peek(8'h0E, 8'h12, "svc_status");
        rd(8'h04); tick();
        chk("svc_partial_clear", 32'(interrupt), 32'd0);
        rd(8'h07); tick();
        chk("svc_to_idle", 32'(interrupt), 32'd0);
        key_in = '0; ticks(10);
        key_in[1] = 1'b1;
        wait_pend(1, 12, n);
        tick();
        chk("req_again", 32'(interrupt), 32'd1);
        rd(8'h04); ack(); key_in = '0; ticks(10);

        // Press pulse on key 3 coincides with a clearing read of port 8'h06.
        key_in[3] = 1'b1; ticks(6);
        rd(8'h06);
        peek(8'h0E, 8'h08, "set_beats_clear");
        rd(8'h06); ack(); key_in = '0; ticks(10);

        // Mask.
        wr_mask(8'h1E);
        key_in[0] = 1'b1; ticks(10);
        peek(8'h0E, 8'h01, "masked_pending");
        peek(8'h0F, 8'h1E, "mask_readback");
        chk("masked_no_irq", 32'(interrupt), 32'd0);
        wr_mask(8'h1F);
        chk("unmask_cycle1", 32'(interrupt), 32'd0);
        tick();
        chk("unmask_cycle2", 32'(interrupt), 32'd1);
        rd(8'h03); ack(); key_in = '0; ticks(10);

        // Randomised traffic, including occasional resets and glitchy keys.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < int'(NK); k++)
                if ($urandom_range(5) == 0) key_in[k] = ~key_in[k];
            port_id       = 8'($urandom_range(16));
            read_strobe   = ($urandom_range(3) == 0);
            write_strobe  = ($urandom_range(2) == 0);
            out_port      = 8'($urandom);
            interrupt_ack = ($urandom_range(5) == 0);
            reset         = ($urandom_range(400) == 0);
            tick();
        end
        reset = 1'b0; read_strobe = 1'b0; write_strobe = 1'b0; interrupt_ack = 1'b0;
        ticks(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
